// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit positions, the sixteen hex
// glyphs built from them, and the frame-state encoding of the scan reader.
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] M_A = 7'(1 << SEG_A);
    localparam logic [6:0] M_B = 7'(1 << SEG_B);
    localparam logic [6:0] M_C = 7'(1 << SEG_C);
    localparam logic [6:0] M_D = 7'(1 << SEG_D);
    localparam logic [6:0] M_E = 7'(1 << SEG_E);
    localparam logic [6:0] M_F = 7'(1 << SEG_F);
    localparam logic [6:0] M_G = 7'(1 << SEG_G);

    localparam logic [6:0] GLYPH_0 = M_A | M_B | M_C | M_D | M_E | M_F;        // 7E
    localparam logic [6:0] GLYPH_1 = M_B | M_C;                                // 30
    localparam logic [6:0] GLYPH_2 = M_A | M_B | M_D | M_E | M_G;              // 6D
    localparam logic [6:0] GLYPH_3 = M_A | M_B | M_C | M_D | M_G;              // 79
    localparam logic [6:0] GLYPH_4 = M_B | M_C | M_F | M_G;                    // 33
    localparam logic [6:0] GLYPH_5 = M_A | M_C | M_D | M_F | M_G;              // 5B
    localparam logic [6:0] GLYPH_6 = M_A | M_C | M_D | M_E | M_F | M_G;        // 5F
    localparam logic [6:0] GLYPH_7 = M_A | M_B | M_C;                          // 70
    localparam logic [6:0] GLYPH_8 = M_A | M_B | M_C | M_D | M_E | M_F | M_G;  // 7F
    localparam logic [6:0] GLYPH_9 = M_A | M_B | M_C | M_D | M_F | M_G;        // 7B
    localparam logic [6:0] GLYPH_A = M_A | M_B | M_C | M_E | M_F | M_G;        // 77
    localparam logic [6:0] GLYPH_B = M_C | M_D | M_E | M_F | M_G;              // 1F
    localparam logic [6:0] GLYPH_C = M_A | M_D | M_E | M_F;                    // 4E
    localparam logic [6:0] GLYPH_D = M_B | M_C | M_D | M_E | M_G;              // 3D
    localparam logic [6:0] GLYPH_E = M_A | M_D | M_E | M_F | M_G;              // 4F
    localparam logic [6:0] GLYPH_F = M_A | M_E | M_F | M_G;                    // 47

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } frame_state_e;

endpackage

// File: rtl/seg7_pattern_to_hex.sv
// Combinational reverse glyph lookup: 7-bit segment pattern to hex nibble.
// Anything that is not one of the sixteen glyphs is flagged illegal and
// returns nibble 0.
module seg7_pattern_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       illegal_o
);

    // Decode the pattern; defaults cover every non-glyph pattern.
    always_comb begin
        nibble_o  = 4'h0;
        illegal_o = 1'b0;
        case (pattern_i)
            GLYPH_0: nibble_o = 4'h0;
            GLYPH_1: nibble_o = 4'h1;
            GLYPH_2: nibble_o = 4'h2;
            GLYPH_3: nibble_o = 4'h3;
            GLYPH_4: nibble_o = 4'h4;
            GLYPH_5: nibble_o = 4'h5;
            GLYPH_6: nibble_o = 4'h6;
            GLYPH_7: nibble_o = 4'h7;
            GLYPH_8: nibble_o = 4'h8;
            GLYPH_9: nibble_o = 4'h9;
            GLYPH_A: nibble_o = 4'hA;
            GLYPH_B: nibble_o = 4'hB;
            GLYPH_C: nibble_o = 4'hC;
            GLYPH_D: nibble_o = 4'hD;
            GLYPH_E: nibble_o = 4'hE;
            GLYPH_F: nibble_o = 4'hF;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Multiplexed seven-segment display reader. Samples the digit-enable and
// segment bus, accepts a digit once its pattern has been stable for
// STABLE_CYCLES samples, and presents the full multi-digit word on a
// valid/ready output once every digit has been captured.
// Optional feature macro: SEG7_DP_EN adds dp_i / dp_o (decimal points).
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | no word pending; a completed frame loads the outputs
// PRESENT | word held on value_o/err_o, waiting for out_ready_i;
//         | a frame completing without a handshake is dropped
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DIGITS-1:0]   dig_en_i,
    input  logic [6:0]          seg_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [4*DIGITS-1:0] value_o,
    output logic [DIGITS-1:0]   err_o,
    output logic                overrun_o
`ifdef SEG7_DP_EN
    ,
    input  logic                dp_i,
    output logic [DIGITS-1:0]   dp_o
`endif
);

    // Counter saturates at STABLE_CYCLES-1; capture fires on the step into it.
    localparam logic [7:0]        CNT_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0]        CNT_PRE = 8'(STABLE_CYCLES - 2);
    localparam logic [DIGITS-1:0] ONE     = DIGITS'(1);

    logic [DIGITS-1:0]   dig_q;
    logic [6:0]          seg_q;
    logic [7:0]          cnt_q, cnt_d;
    logic                sample_eq;
    logic                capture;
    logic                dig_onehot;
    logic [3:0]          lut_nibble;
    logic                lut_illegal;

    logic [4*DIGITS-1:0] slot_q, slot_d;
    logic [DIGITS-1:0]   slot_err_q, slot_err_d;
    logic [DIGITS-1:0]   seen_q, seen_d;

    frame_state_e        state_q, state_d;
    logic                frame_done;
    logic                handshake;
    logic                load;
    logic                overrun_d;
    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0]   err_q;
    logic                overrun_q;

`ifdef SEG7_DP_EN
    logic                dp_smp_q;
    logic [DIGITS-1:0]   dp_slot_q, dp_slot_d;
    logic [DIGITS-1:0]   dp_out_q;
    logic                dp_eq;
    assign dp_eq = (dp_i == dp_smp_q);
`else
    logic                dp_eq;
    assign dp_eq = 1'b1;
`endif

    // The incoming value is compared against the current sample, so a change
    // zeroes the counter on the same edge it enters the sample register.
    assign sample_eq  = (dig_en_i == dig_q) && (seg_i == seg_q) && dp_eq;
    assign capture    = sample_eq && (cnt_q == CNT_PRE);
    assign dig_onehot = (dig_q != '0) && ((dig_q & (dig_q - ONE)) == '0);

    seg7_pattern_to_hex u_lut (
        .pattern_i (seg_q),
        .nibble_o  (lut_nibble),
        .illegal_o (lut_illegal)
    );

    // Stability counter next value.
    always_comb begin
        cnt_d = cnt_q;
        if (!sample_eq) begin
            cnt_d = 8'd0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Input sample stage and stability counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q <= '0;
            seg_q <= '0;
            cnt_q <= '0;
        end else begin
            dig_q <= dig_en_i;
            seg_q <= seg_i;
            cnt_q <= cnt_d;
        end
    end

    // Slot update: a completed frame clears seen, then a capture on the same
    // edge starts the next frame's seen set.
    always_comb begin
        slot_d     = slot_q;
        slot_err_d = slot_err_q;
        seen_d     = frame_done ? '0 : seen_q;
`ifdef SEG7_DP_EN
        dp_slot_d  = dp_slot_q;
`endif
        if (capture && dig_onehot) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (dig_q[k]) begin
                    slot_d[4*k +: 4] = lut_nibble;
                    slot_err_d[k]    = lut_illegal;
                    seen_d[k]        = 1'b1;
`ifdef SEG7_DP_EN
                    dp_slot_d[k]     = dp_smp_q;
`endif
                end
            end
        end
    end

    // Per-digit slot storage and seen mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q     <= '0;
            slot_err_q <= '0;
            seen_q     <= '0;
        end else begin
            slot_q     <= slot_d;
            slot_err_q <= slot_err_d;
            seen_q     <= seen_d;
        end
    end

    assign frame_done = &seen_q;
    assign handshake  = (state_q == PRESENT) && out_ready_i;

    // Frame FSM next state: load when the output is free or being freed.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        overrun_d = 1'b0;
        if (frame_done) begin
            if ((state_q == COLLECT) || handshake) begin
                load    = 1'b1;
                state_d = PRESENT;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (handshake) begin
            state_d = COLLECT;
        end
    end

    // Frame FSM state and output word registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= COLLECT;
            value_q   <= '0;
            err_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            overrun_q <= overrun_d;
            if (load) begin
                value_q <= slot_q;
                err_q   <= slot_err_q;
            end
        end
    end

`ifdef SEG7_DP_EN
    // Decimal point sample, slots and frozen output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_smp_q  <= 1'b0;
            dp_slot_q <= '0;
            dp_out_q  <= '0;
        end else begin
            dp_smp_q  <= dp_i;
            dp_slot_q <= dp_slot_d;
            if (load) begin
                dp_out_q <= dp_slot_q;
            end
        end
    end

    assign dp_o = dp_out_q;
`endif

    assign out_valid_o = (state_q == PRESENT);
    assign value_o     = value_q;
    assign err_o       = err_q;
    assign overrun_o   = overrun_q;

endmodule
